prbs_checker: RTL and testbench

Receive-side companion of the team's PRBS transmit generator: a self-synchronizing checker that consumes a serial bit stream at baud rate, locks onto the PRBS sequence, and counts bit errors for BER measurement. It sits after the receive slicer/decision stage in the loopback test path. Its parameters match the generator: a Fibonacci LFSR with feedback from stage `PRBS_ORDER` and stage `FB_TAP`, giving s[n] = s[n-PRBS_ORDER] ^ s[n-FB_TAP].

---
 rtl/prbs_checker.sv | 113 +++++++++++
 tb/tb_prbs_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronizing PRBS receive checker with saturating bit/error counters.
// Define PRBS_CHK_AUTO_UNLOCK_EN to drop lock after UNLOCK_ERRS errors within a WINDOW_LEN-bit window.
module prbs_checker #(
  parameter int PRBS_ORDER  = 9,
  parameter int FB_TAP      = 5,
  parameter int LOCK_THRESH = 16,
  parameter int WINDOW_LEN  = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_bit,
  input  logic             i_clear,
  input  logic             i_resync,
  output logic             o_locked,
  output logic             o_bit_err,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  if (FB_TAP < 1 || FB_TAP >= PRBS_ORDER || WINDOW_LEN < 1 || UNLOCK_ERRS < 1) begin : g_bad_params
    $error("prbs_checker: invalid parameters");
  end
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;
  state_t state, state_n;
  logic [PRBS_ORDER-1:0] hist, hist_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [CNT_W-1:0] bit_cnt_n, err_cnt_n;
  logic bit_err_n, pred, miss, lock_bit;
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
  localparam int WBW = $clog2(WINDOW_LEN + 1);
  localparam int WEW = $clog2(UNLOCK_ERRS + 1);
  logic [WBW-1:0] win_bits, win_bits_n;
  logic [WEW-1:0] win_err, win_err_n;
  logic win_wrap;
  assign win_wrap = win_bits == WBW'(WINDOW_LEN - 1);
`endif
  assign pred = hist[PRBS_ORDER-1] ^ hist[FB_TAP-1];
  assign miss = i_bit ^ pred;
  assign lock_bit = i_enable && !i_resync && state == LOCKED;
  assign o_locked = state == LOCKED;
  // Once locked the history flywheels on its own prediction so a channel error never propagates.
  always_comb begin
    state_n = state;
    hist_n = i_enable ? {hist[PRBS_ORDER-2:0], lock_bit ? pred : i_bit} : hist;
    match_n = match_cnt;
    bit_cnt_n = o_bit_count;
    err_cnt_n = o_err_count;
    bit_err_n = 1'b0;
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
    win_bits_n = win_bits;
    win_err_n = win_err;
`endif
    if (i_resync) begin
      state_n = SEARCH;
      match_n = '0;
    end else if (state == SEARCH) begin
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
      win_bits_n = '0;
      win_err_n = '0;
`endif
      if (i_enable) match_n = (hist == '0 || miss) ? '0 : match_cnt + 1'b1;
      if (i_enable && hist != '0 && !miss && match_cnt == MW'(LOCK_THRESH - 1)) begin
        state_n = LOCKED;
        match_n = '0;
      end
    end else if (i_enable) begin
      bit_cnt_n = &o_bit_count ? o_bit_count : o_bit_count + 1'b1;
      err_cnt_n = (miss && !(&o_err_count)) ? o_err_count + 1'b1 : o_err_count;
      bit_err_n = miss;
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
      win_bits_n = win_wrap ? '0 : win_bits + 1'b1;
      win_err_n = win_wrap ? '0 : win_err + WEW'(miss);
      if (miss && win_err == WEW'(UNLOCK_ERRS - 1)) state_n = SEARCH;
`endif
    end
    if (i_clear) begin
      bit_cnt_n = '0;
      err_cnt_n = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= SEARCH;
    else state <= state_n;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hist <= '0;
      match_cnt <= '0;
      o_bit_err <= 1'b0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      hist <= hist_n;
      match_cnt <= match_n;
      o_bit_err <= bit_err_n;
      o_bit_count <= bit_cnt_n;
      o_err_count <= err_cnt_n;
    end
  end
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      win_bits <= '0;
      win_err <= '0;
    end else begin
      win_bits <= win_bits_n;
      win_err <= win_err_n;
    end
  end
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized and directed bench for prbs_checker against a queue-based bit-level model.
module tb_prbs_checker;
  localparam int ORDER = 9, TAP = 5, LT = 16, WL = 64, UE = 8;
  logic clk = 0, rst_n = 0, en = 0, bin = 0, clr = 0, rsy = 0;
  logic locked, berr, locked4, berr4;
  logic [31:0] bcnt, ecnt;
  logic [3:0] bcnt4, ecnt4;
  logic [8:0] gen = 9'h1AA;
  int checks = 0, errors = 0, pulses = 0;
  bit m_hq[$];
  bit m_locked, m_pulse;
  int m_run, win_n, win_e;
  longint m_bits, m_errs;

  always #5 clk = ~clk;

  prbs_checker #(.PRBS_ORDER(ORDER), .FB_TAP(TAP), .LOCK_THRESH(LT), .WINDOW_LEN(WL),
                 .UNLOCK_ERRS(UE), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_bit(bin), .i_clear(clr), .i_resync(rsy),
    .o_locked(locked), .o_bit_err(berr), .o_bit_count(bcnt), .o_err_count(ecnt));

  prbs_checker #(.PRBS_ORDER(ORDER), .FB_TAP(TAP), .LOCK_THRESH(LT), .WINDOW_LEN(WL),
                 .UNLOCK_ERRS(UE), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_bit(bin), .i_clear(clr), .i_resync(rsy),
    .o_locked(locked4), .o_bit_err(berr4), .o_bit_count(bcnt4), .o_err_count(ecnt4));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return v > mx ? mx : v;
  endfunction

  function automatic logic nextb();
    logic b = gen[8] ^ gen[4];
    gen = {gen[7:0], b};
    return b;
  endfunction

  task automatic m_reset();
    m_hq.delete();
    repeat (ORDER) m_hq.push_back(1'b0);
    m_locked = 0; m_pulse = 0; m_run = 0; win_n = 0; win_e = 0; m_bits = 0; m_errs = 0;
  endtask

  // Reference: m_hq[0] is the newest bit; spec rules applied once per valid bit.
  always @(posedge clk or negedge rst_n) begin
    bit p, e, nb, z;
    if (!rst_n) m_reset();
    else begin
      p = m_hq[ORDER-1] ^ m_hq[TAP-1];
      e = bin != p;
      z = 1;
      foreach (m_hq[i]) if (m_hq[i]) z = 0;
      nb = (m_locked && !rsy) ? p : bin;
      m_pulse = 0;
      if (rsy) begin
        m_locked = 0;
        m_run = 0;
      end else if (en && !m_locked) begin
        m_run = (z || e) ? 0 : m_run + 1;
        if (m_run == LT) begin
          m_locked = 1; m_run = 0; win_n = 0; win_e = 0;
        end
      end else if (en) begin
        m_bits++;
        if (e) begin m_errs++; m_pulse = 1; win_e++; end
        win_n++;
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
        if (e && win_e == UE) m_locked = 0;
        if (win_n == WL) begin win_n = 0; win_e = 0; end
`endif
      end
      if (en) begin
        m_hq.push_front(nb);
        void'(m_hq.pop_back());
      end
      if (clr) begin m_bits = 0; m_errs = 0; end
    end
  end

  always @(negedge clk) begin
    chk("locked", locked, m_locked);
    chk("bit_err", berr, m_pulse);
    chk("bit_count", bcnt, sat(m_bits, 32));
    chk("err_count", ecnt, sat(m_errs, 32));
    chk("locked4", locked4, m_locked);
    chk("bit_count4", bcnt4, sat(m_bits, 4));
    chk("err_count4", ecnt4, sat(m_errs, 4));
    if (berr) pulses++;
  end

  task automatic send(input logic b, input int gap);
    en = 1; bin = b;
    @(negedge clk);
    en = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic lock_up(input int gap, input string name);
    int n = 0;
    while (!locked && n < 25) begin send(nextb(), gap); n++; end
    chk(name, locked, 1);
  endtask

  initial begin
    int p0;
    @(negedge clk);
    chk("reset_locked", locked, 0);
    chk("reset_count", bcnt, 0);
    @(negedge clk);
    rst_n = 1;
    lock_up(3, "clean_lock");
    p0 = pulses;
    repeat (10000) send(nextb(), 3);
    chk("clean_bits", bcnt, 10000);
    chk("clean_errs", ecnt, 0);
    chk("clean_pulses", pulses - p0, 0);
    send(~nextb(), 0);
    chk("single_pulse", berr, 1);
    chk("single_err", ecnt, 1);
    chk("single_locked", locked, 1);
    send(nextb(), 0);
    chk("pulse_once", berr, 0);
    rsy = 1;
    @(negedge clk);
    rsy = 0;
    chk("resync_unlock", locked, 0);
    lock_up(0, "relock");
    clr = 1;
    send(nextb(), 0);
    clr = 0;
    chk("clear_bits", bcnt, 0);
    chk("clear_errs", ecnt, 0);
    for (int i = 0; i < 40; i++) begin
      send(nextb() ^ (i % 5 == 0), 0);
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
      if (i == 35) chk("unlock_edge", locked, 0);
`else
      if (i == 35) chk("no_unlock", locked, 1);
`endif
    end
    chk("window_errs", ecnt, 8);
    lock_up(0, "relock2");
    clr = 1;
    @(negedge clk);
    clr = 0;
    repeat (20) send(~nextb(), 0);
`ifdef PRBS_CHK_AUTO_UNLOCK_EN
    chk("burst_unlock", locked, 0);
`else
    chk("burst_sat4", ecnt4, 15);
    chk("burst_err32", ecnt, 20);
`endif
    lock_up(0, "prereset_lock");
    repeat (5) send(nextb(), 0);
    #3 rst_n = 0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_bits", bcnt, 0);
    chk("async_errs", ecnt, 0);
    chk("async_errs4", ecnt4, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (1000) send(1'b0, 0);
    chk("zero_locked", locked, 0);
    chk("zero_bits", bcnt, 0);
    chk("zero_errs", ecnt, 0);
    lock_up(3, "relock_after_reset");
    for (int c = 0; c < 3000; c++) begin
      en = $urandom_range(0, 3) != 0;
      bin = en ? nextb() ^ ($urandom_range(0, 99) < 4) : 1'b0;
      clr = $urandom_range(0, 199) == 0;
      rsy = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    en = 0; clr = 0; rsy = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
